// File: rtl/button_step_ctrl.sv
// Set-button conditioner: synchronises, debounces and arbitrates the up/down push-buttons
// and turns them into one-cycle step strobes with press-and-hold auto-repeat.
module button_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter int unsigned CNT_W           = 27,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_ena,
  input  logic i_btn_up,
  input  logic i_btn_down,
  output logic o_up,
  output logic o_down,
  output logic o_held
);

  localparam int unsigned BTN_UP   = 0;
  localparam int unsigned BTN_DOWN = 1;

  localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST    = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST   = CNT_W'(REPEAT_PERIOD - 1);

  // Raw pin level that means "not pressed" for both buttons.
  localparam logic [1:0] RELEASED_RAW = {2{BTN_ACTIVE_LOW}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT,
    ST_LOCK
  } state_t;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_t;

  logic [1:0]       raw_pins;
  logic [1:0]       sync_meta;
  logic [1:0]       sync_pins;
  logic [1:0]       pressed;
  logic [1:0]       db_pressed;
  logic [CNT_W-1:0] db_cnt [2];

  state_t           state;
  state_t           state_nxt;
  dir_t             dir;
  dir_t             dir_nxt;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_nxt;
  logic [CNT_W-1:0] timer_last;
  logic             step;
  logic             up_nxt;
  logic             down_nxt;
  logic             dir_pressed;
  logic             other_pressed;

  assign raw_pins = {i_btn_down, i_btn_up};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_meta <= RELEASED_RAW;
      sync_pins <= RELEASED_RAW;
    end else begin
      sync_meta <= raw_pins;
      sync_pins <= sync_meta;
    end
  end

  assign pressed = sync_pins ^ RELEASED_RAW;

  // Debounced level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      db_pressed <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pressed[i] == db_pressed[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DEBOUNCE_LAST) begin
          db_pressed[i] <= ~db_pressed[i];
          db_cnt[i]     <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign dir_pressed   = (dir == DIR_DOWN) ? db_pressed[BTN_DOWN] : db_pressed[BTN_UP];
  assign other_pressed = (dir == DIR_DOWN) ? db_pressed[BTN_UP]   : db_pressed[BTN_DOWN];
  assign timer_last    = (state == ST_DELAY) ? DELAY_LAST : PERIOD_LAST;

  // NOTE: every signal gets a default first so no path through the block can infer a latch.
  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    timer_nxt = timer;
    step      = 1'b0;

    if (!i_ena) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (db_pressed[BTN_UP] ^ db_pressed[BTN_DOWN]) begin
            dir_nxt   = db_pressed[BTN_DOWN] ? DIR_DOWN : DIR_UP;
            step      = 1'b1;
            timer_nxt = '0;
            state_nxt = ST_DELAY;
          end else if (&db_pressed) begin
            state_nxt = ST_LOCK;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          // Exits take priority over the repeat timer, so the exit cycle never steps.
          if (other_pressed) begin
            state_nxt = ST_LOCK;
          end else if (!dir_pressed) begin
            state_nxt = ST_IDLE;
          end else if (timer == timer_last) begin
            step      = 1'b1;
            timer_nxt = '0;
            state_nxt = ST_REPEAT;
          end else begin
            timer_nxt = timer + 1'b1;
          end
        end
        ST_LOCK: begin
          if (db_pressed == 2'b00) begin
            state_nxt = ST_IDLE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end

    up_nxt   = step && (dir_nxt == DIR_UP);
    down_nxt = step && (dir_nxt == DIR_DOWN);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= ST_IDLE;
      dir    <= DIR_UP;
      timer  <= '0;
      o_up   <= 1'b0;
      o_down <= 1'b0;
    end else begin
      state  <= state_nxt;
      dir    <= dir_nxt;
      timer  <= timer_nxt;
      o_up   <= up_nxt;
      o_down <= down_nxt;
    end
  end

  assign o_held = (state == ST_DELAY) || (state == ST_REPEAT);

endmodule

// File: tb/tb_button_step_ctrl.sv
// Bench for button_step_ctrl: directed scenarios plus random button/enable/reset traffic,
// all checked cycle by cycle against a schedule-based reference model.
module tb_button_step_ctrl;

  localparam int DEB        = 4;
  localparam int RDLY       = 20;
  localparam int RPER       = 5;
  localparam bit ACTIVE_LOW = 1'b0;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  logic i_ena = 1'b0;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic o_up;
  logic o_down;
  logic o_held;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int base  = 0;
  int up_times[$];
  int dn_times[$];
  logic prev_strobe = 1'b0;

  // Reference model: pressed-level pipeline, disagreement run lengths, and an absolute
  // cycle number at which the next auto-repeat step is due.
  int m_s1[2];
  int m_s2[2];
  int m_db[2];
  int m_run[2];
  int m_mode;      // 0 idle, 1 holding (delay/repeat), 2 locked
  int m_dir;       // 0 up, 1 down
  int m_next;
  logic e_up = 1'b0;
  logic e_dn = 1'b0;
  logic e_held = 1'b0;

  button_step_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RDLY),
    .REPEAT_PERIOD  (RPER),
    .CNT_W          (8),
    .BTN_ACTIVE_LOW (ACTIVE_LOW)
  ) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_ena     (i_ena),
    .i_btn_up  (btn_up),
    .i_btn_down(btn_down),
    .o_up      (o_up),
    .o_down    (o_down),
    .o_held    (o_held)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  task automatic model_edge();
    int pin[2];
    int strobe;
    pin[0] = int'(btn_up ^ ACTIVE_LOW);
    pin[1] = int'(btn_down ^ ACTIVE_LOW);
    strobe = 0;
    if (i_reset) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_run[i] = 0;
      end
      m_mode = 0;
      m_dir  = 0;
      m_next = 0;
    end else begin
      if (!i_ena) begin
        m_mode = 0;
      end else if (m_mode == 0) begin
        if (m_db[0] + m_db[1] == 1) begin
          m_dir  = m_db[1];
          strobe = 1;
          m_next = cyc + RDLY;
          m_mode = 1;
        end else if (m_db[0] + m_db[1] == 2) begin
          m_mode = 2;
        end
      end else if (m_mode == 1) begin
        if (m_db[1 - m_dir] == 1)    m_mode = 2;
        else if (m_db[m_dir] == 0)   m_mode = 0;
        else if (cyc == m_next) begin
          strobe = 1;
          m_next = cyc + RPER;
        end
      end else begin
        if (m_db[0] + m_db[1] == 0) m_mode = 0;
      end
      for (int i = 0; i < 2; i++) begin
        if (m_s2[i] == m_db[i]) begin
          m_run[i] = 0;
        end else begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_db[i]  = 1 - m_db[i];
            m_run[i] = 0;
          end
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = pin[i];
      end
    end
    e_up   = (strobe == 1) && (m_dir == 0);
    e_dn   = (strobe == 1) && (m_dir == 1);
    e_held = (m_mode == 1);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      cyc++;
      model_edge();
      #1;
      check("up", 32'(o_up), 32'(e_up));
      check("down", 32'(o_down), 32'(e_dn));
      check("held", 32'(o_held), 32'(e_held));
      check("exclusive", 32'(o_up & o_down), 32'd0);
      check("no_back_to_back", 32'((o_up | o_down) & prev_strobe), 32'd0);
      prev_strobe = o_up | o_down;
      if (o_up)   up_times.push_back(cyc);
      if (o_down) dn_times.push_back(cyc);
    end
  endtask

  task automatic clear_log();
    up_times.delete();
    dn_times.delete();
  endtask

  initial begin
    logic [9:0] glitch;
    int len;

    // 1: reset with up pressed, then first step 2+DEB+1 cycles after release
    i_reset = 1'b1; i_ena = 1'b1; btn_up = 1'b1;
    step(3);
    check("t1_rst_up", 32'(o_up), 32'd0);
    check("t1_rst_down", 32'(o_down), 32'd0);
    check("t1_rst_held", 32'(o_held), 32'd0);
    i_reset = 1'b0; base = cyc; clear_log();
    step(8);
    check("t1_first_up", 32'(qat(up_times, 0) - base), 32'd7);
    btn_up = 1'b0;
    step(12);
    check("t1_idle", 32'(o_held), 32'd0);

    // 2: short press and glitch train never step
    clear_log();
    btn_up = 1'b1; step(3);
    btn_up = 1'b0; step(12);
    glitch = 10'b0110101101;
    for (int i = 0; i < 10; i++) begin
      btn_up = glitch[i];
      step(1);
    end
    btn_up = 1'b0; step(12);
    check("t2_no_strobe", 32'(up_times.size() + dn_times.size()), 32'd0);

    // 3: long hold: t0, t0+RDLY, then every RPER
    clear_log();
    btn_up = 1'b1; base = cyc;
    step(67);
    check("t3_count", 32'(up_times.size()), 32'd10);
    check("t3_first", 32'(qat(up_times, 0) - base), 32'd7);
    check("t3_second", 32'(qat(up_times, 1) - base), 32'd27);
    check("t3_third", 32'(qat(up_times, 2) - base), 32'd32);
    check("t3_last", 32'(qat(up_times, 9) - base), 32'd67);
    check("t3_no_down", 32'(dn_times.size()), 32'd0);
    btn_up = 1'b0; step(12);

    // 4: second button during repeat locks until both released
    clear_log();
    btn_up = 1'b1;
    step(35);
    check("t4_repeat_held", 32'(o_held), 32'd1);
    btn_down = 1'b1; step(10);
    check("t4_locked", 32'(o_held), 32'd0);
    clear_log();
    btn_down = 1'b0; step(15);
    check("t4_lock_after_down_release", 32'(up_times.size() + dn_times.size()), 32'd0);
    btn_up = 1'b0; step(12);
    check("t4_lock_quiet", 32'(up_times.size() + dn_times.size()), 32'd0);

    // 5: enable drop during hold, then immediate fresh step on re-enable
    clear_log();
    btn_down = 1'b1;
    step(40);
    check("t5_pre_count", 32'(dn_times.size()), 32'd4);
    i_ena = 1'b0; clear_log();
    step(10);
    check("t5_disabled_quiet", 32'(dn_times.size()), 32'd0);
    i_ena = 1'b1; base = cyc;
    step(1);
    check("t5_resume_step", 32'(o_down), 32'd1);
    step(26);
    check("t5_delay_again", 32'(qat(dn_times, 1) - base), 32'd21);
    check("t5_repeat_again", 32'(qat(dn_times, 2) - base), 32'd26);
    check("t5_no_up", 32'(up_times.size()), 32'd0);

    // 6: reset mid-repeat forces a full re-debounce
    i_reset = 1'b1; step(1);
    i_reset = 1'b0; base = cyc; clear_log();
    step(1);
    check("t6_no_strobe_after_reset", 32'(o_down), 32'd0);
    step(8);
    check("t6_first_down", 32'(qat(dn_times, 0) - base), 32'd7);
    btn_down = 1'b0; step(12);

    // Random traffic against the model
    for (int it = 0; it < 120; it++) begin
      btn_up   = ($urandom_range(0, 2) == 0);
      btn_down = ($urandom_range(0, 2) == 0);
      i_ena    = ($urandom_range(0, 9) != 0);
      i_reset  = ($urandom_range(0, 29) == 0);
      len      = i_reset ? 1 : int'($urandom_range(1, 50));
      step(len);
      i_reset  = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
